// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer on the camera pixel clock: arms on request, captures one
// vsync-bounded frame, checks its geometry and reports done/err to the register block.
module cam_capture_ctrl #(
    parameter int H_PIX    = 160,
    parameter int V_LINES  = 120,
    parameter int TIMEOUT  = 500000,
    localparam int LW      = $clog2(V_LINES + 1) + 1,
    localparam int PW      = $clog2(H_PIX + 2),
    localparam int TW      = $clog2(TIMEOUT)
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          start,
    input  logic          cont,
    input  logic          abort,
    input  logic          vsync,
    input  logic          href,
    input  logic          px_wr,
    output logic          cap_en,
    output logic          addr_clr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [7:0]    frame_cnt,
    output logic [LW-1:0] line_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_CAPT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            vs_q, vs_d;
    logic            hr_q, hr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   px_cnt_q, px_cnt_d;
    logic [PW-1:0]   px_base;
    logic            geom_bad_q, geom_bad_d;
    logic            good_q, good_d;
    logic            to_q, to_d;
    logic            cap_en_q, cap_en_d;
    logic            addr_clr_q, addr_clr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic [LW-1:0]   line_cnt_q, line_cnt_d;

    logic vs_fall, vs_rise, hr_rise, hr_fall, timeout_hit;

    assign vs_fall = vs_q & ~vsync;
    assign vs_rise = ~vs_q & vsync;
    assign hr_rise = ~hr_q & href;
    assign hr_fall = hr_q & ~href;

    // The increment taken this cycle lands the timer on TIMEOUT-1.
    assign timeout_hit = ((state_q == S_ARM) || (state_q == S_CAPT)) &&
                         (timer_q == TW'(TIMEOUT - 2));

    always_comb begin
        state_d     = state_q;
        vs_d        = vsync;
        hr_d        = href;
        timer_d     = timer_q;
        px_cnt_d    = px_cnt_q;
        px_base     = '0;
        geom_bad_d  = geom_bad_q;
        good_d      = good_q;
        to_d        = to_q;
        cap_en_d    = cap_en_q;
        addr_clr_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        frame_cnt_d = frame_cnt_q;
        line_cnt_d  = line_cnt_q;

        case (state_q)
            S_IDLE: begin
                cap_en_d = 1'b0;
                if (start && !abort) begin
                    state_d    = S_ARM;
                    timer_d    = '0;
                    err_code_d = 2'd0;
                    to_d       = 1'b0;
                end
            end

            S_ARM: begin
                timer_d = timer_q + TW'(1);
                if (abort) begin
                    state_d    = S_IDLE;
                    cap_en_d   = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                end else if (timeout_hit) begin
                    state_d  = S_FIN;
                    to_d     = 1'b1;
                    cap_en_d = 1'b0;
                end else if (vs_fall) begin
                    state_d    = S_CAPT;
                    cap_en_d   = 1'b1;
                    addr_clr_d = 1'b1;
                    line_cnt_d = '0;
                    px_cnt_d   = '0;
                    geom_bad_d = 1'b0;
                end
            end

            S_CAPT: begin
                timer_d = timer_q + TW'(1);
                if (abort) begin
                    state_d    = S_IDLE;
                    cap_en_d   = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                end else if (timeout_hit) begin
                    state_d  = S_FIN;
                    to_d     = 1'b1;
                    cap_en_d = 1'b0;
                end else if (vs_rise) begin
                    state_d  = S_FIN;
                    cap_en_d = 1'b0;
                    good_d   = !geom_bad_q && (line_cnt_q == LW'(V_LINES));
                end else begin
                    // A write in the same cycle as href rising is the first pixel of the new line.
                    px_base  = hr_rise ? '0 : px_cnt_q;
                    px_cnt_d = px_base;
                    if (href && px_wr && (px_base != PW'(H_PIX + 1)))
                        px_cnt_d = px_base + PW'(1);
                    if (hr_rise && (line_cnt_q != '1))
                        line_cnt_d = line_cnt_q + LW'(1);
                    if (hr_fall && (px_cnt_q != PW'(H_PIX)))
                        geom_bad_d = 1'b1;
                end
            end

            S_FIN: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    cap_en_d   = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                end else begin
                    if (to_q) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                    end else if (good_q) begin
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        err_code_d  = 2'd0;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                    end
                    if (cont) begin
                        state_d = S_ARM;
                        timer_d = '0;
                        to_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            vs_q        <= 1'b1;
            hr_q        <= 1'b0;
            timer_q     <= '0;
            px_cnt_q    <= '0;
            geom_bad_q  <= 1'b0;
            good_q      <= 1'b0;
            to_q        <= 1'b0;
            cap_en_q    <= 1'b0;
            addr_clr_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            frame_cnt_q <= 8'd0;
            line_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            vs_q        <= vs_d;
            hr_q        <= hr_d;
            timer_q     <= timer_d;
            px_cnt_q    <= px_cnt_d;
            geom_bad_q  <= geom_bad_d;
            good_q      <= good_d;
            to_q        <= to_d;
            cap_en_q    <= cap_en_d;
            addr_clr_q  <= addr_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            frame_cnt_q <= frame_cnt_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

    assign cap_en    = cap_en_q;
    assign addr_clr  = addr_clr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign frame_cnt = frame_cnt_q;
    assign line_cnt  = line_cnt_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl: stimulus queues expected addr_clr/done/err
// events, a negedge monitor pops and compares each one the DUT produces.
`timescale 1ns/1ps
module tb_cam_capture_ctrl;

    localparam int H_PIX   = 4;
    localparam int V_LINES = 3;
    localparam int TIMEOUT = 50;
    localparam int LW      = $clog2(V_LINES + 1) + 1;

    logic          pclk = 1'b0;
    logic          rst, start, cont, abort, vsync, href, px_wr;
    logic          cap_en, addr_clr, busy, done, err;
    logic [1:0]    err_code;
    logic [7:0]    frame_cnt;
    logic [LW-1:0] line_cnt;

    cam_capture_ctrl #(.H_PIX(H_PIX), .V_LINES(V_LINES), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .rst(rst), .start(start), .cont(cont), .abort(abort),
        .vsync(vsync), .href(href), .px_wr(px_wr),
        .cap_en(cap_en), .addr_clr(addr_clr), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .frame_cnt(frame_cnt), .line_cnt(line_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic          is_clr;
        logic          done;
        logic          err;
        logic [1:0]    code;
        logic [7:0]    fcnt;
        logic [LW-1:0] lcnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;
    logic mon_ok;

    // Monitor: every addr_clr/done/err pulse must match the next queued expectation.
    always @(negedge pclk) begin
        if (rst && (addr_clr || done || err)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event actual addr_clr=%0b done=%0b err=%0b code=%0d required no event",
                         addr_clr, done, err, err_code);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.is_clr)
                    mon_ok = addr_clr && cap_en && !done && !err;
                else
                    mon_ok = !addr_clr && (done == mon_e.done) && (err == mon_e.err) &&
                             (err_code == mon_e.code) && (frame_cnt == mon_e.fcnt) &&
                             (line_cnt == mon_e.lcnt);
                if (!mon_ok)
                    $display("FAIL event actual clr=%0b cap=%0b done=%0b err=%0b code=%0d fcnt=%0d lcnt=%0d required clr=%0b done=%0b err=%0b code=%0d fcnt=%0d lcnt=%0d",
                             addr_clr, cap_en, done, err, err_code, frame_cnt, line_cnt,
                             mon_e.is_clr, mon_e.done, mon_e.err, mon_e.code, mon_e.fcnt, mon_e.lcnt);
                else
                    $display("event ok clr=%0b done=%0b err=%0b code=%0d fcnt=%0d lcnt=%0d",
                             addr_clr, done, err, err_code, frame_cnt, line_cnt);
                if (!mon_ok) errors++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("check %s = %0d", name, act);
        end
    endtask

    task automatic push_clr();
        exp_t e;
        e = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0, '0};
        q.push_back(e);
    endtask

    task automatic push_res(input logic d, input logic e_err, input logic [1:0] code,
                            input logic [7:0] fcnt, input logic [LW-1:0] lcnt);
        exp_t e;
        e = '{1'b0, d, e_err, code, fcnt, lcnt};
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic line(input int npx);
        href = 1'b1;
        cyc(1);
        for (int i = 0; i < npx; i++) begin
            px_wr = 1'b1;
            cyc(1);
        end
        px_wr = 1'b0;
        href  = 1'b0;
        cyc(2);
    endtask

    // Ends in the FIN cycle: the vs_rise edge has just been sampled.
    task automatic run_frame(input int nl, input int bad_line, input int bad_px);
        vsync = 1'b0;
        cyc(1);
        for (int l = 0; l < nl; l++)
            line((l == bad_line) ? bad_px : H_PIX);
        vsync = 1'b1;
        cyc(1);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    logic [7:0] fcnt_exp;
    int         n;
    logic       cap_seen;

    initial begin
        rst = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
        vsync = 1'b1; href = 1'b0; px_wr = 1'b0;
        fcnt_exp = 8'd0;
        #12;
        chk("rst_cap_en", cap_en, 0);
        chk("rst_addr_clr", addr_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_line_cnt", line_cnt, 0);
        @(posedge pclk); #1;
        rst = 1'b1;
        cyc(2);

        // Single good frame
        do_start();
        chk("start_busy", busy, 1);
        chk("arm_cap_en", cap_en, 0);
        push_clr();
        vsync = 1'b0;
        cyc(1);
        chk("vs_fall_cap_en", cap_en, 1);
        for (int l = 0; l < V_LINES; l++) line(H_PIX);
        vsync = 1'b1;
        fcnt_exp++;
        push_res(1'b1, 1'b0, 2'd0, fcnt_exp, LW'(3));
        cyc(1);
        chk("vs_rise_cap_en", cap_en, 0);
        chk("fin_no_done_yet", done, 0);
        cyc(1);
        chk("good_done", done, 1);
        chk("good_busy_after", busy, 0);

        // Geometry: line 2 short
        do_start();
        push_clr();
        push_res(1'b0, 1'b1, 2'd2, fcnt_exp, LW'(3));
        run_frame(3, 1, 3);
        cyc(1);
        chk("short_line_err", err, 1);
        cyc(3);
        chk("err_code_holds", err_code, 2);

        // Geometry: one line too many
        do_start();
        chk("start_clears_code", err_code, 0);
        push_clr();
        push_res(1'b0, 1'b1, 2'd2, fcnt_exp, LW'(4));
        run_frame(4, -1, 0);
        cyc(1);
        chk("extra_line_cnt", line_cnt, 4);

        // Timeout with vsync held high
        do_start();
        push_res(1'b0, 1'b1, 2'd1, fcnt_exp, LW'(4));
        n = 0;
        cap_seen = 1'b0;
        while (!err && n < 200) begin
            cyc(1);
            n++;
            if (cap_en) cap_seen = 1'b1;
        end
        chk("timeout_cycle", n, TIMEOUT);
        chk("timeout_code", err_code, 1);
        chk("timeout_cap_never", cap_seen, 0);
        chk("timeout_idle", busy, 0);

        // Abort mid-capture, with an ignored start during capture
        do_start();
        push_clr();
        vsync = 1'b0;
        cyc(1);
        line(H_PIX);
        do_start();
        chk("start_ignored_busy", busy, 1);
        chk("start_ignored_cap", cap_en, 1);
        push_res(1'b0, 1'b1, 2'd3, fcnt_exp, LW'(1));
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_cap_en", cap_en, 0);
        chk("abort_err", err, 1);
        chk("abort_busy", busy, 0);
        vsync = 1'b1;
        cyc(2);
        chk("abort_frame_cnt", frame_cnt, fcnt_exp);

        // Continuous mode: 256 good frames wrap frame_cnt through 255 -> 0
        cont = 1'b1;
        do_start();
        for (int f = 0; f < 256; f++) begin
            push_clr();
            fcnt_exp++;
            push_res(1'b1, 1'b0, 2'd0, fcnt_exp, LW'(3));
            run_frame(3, -1, 0);
            if (f == 0) vsync = 1'b0;
            if (f == 255) cont = 1'b0;
            cyc(1);
            if (f < 3 || f == 255) chk("cont_busy", busy, (f == 255) ? 0 : 1);
            if (fcnt_exp == 8'd0) chk("frame_cnt_wrap", frame_cnt, 0);
            if (f == 0) begin
                // vs_fall seen in FIN is skipped; no addr_clr may follow
                cyc(3);
                chk("skipped_frame_cap", cap_en, 0);
                vsync = 1'b1;
                cyc(2);
            end
        end

        // Asynchronous reset mid-capture
        do_start();
        push_clr();
        vsync = 1'b0;
        cyc(1);
        line(H_PIX);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cap_en", cap_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        @(posedge pclk); #1;
        rst = 1'b1;
        fcnt_exp = 8'd0;
        cyc(5);
        chk("post_rst_no_capture", cap_en, 0);
        vsync = 1'b1;
        cyc(1);
        do_start();
        push_clr();
        fcnt_exp++;
        push_res(1'b1, 1'b0, 2'd0, fcnt_exp, LW'(3));
        run_frame(3, -1, 0);
        cyc(3);

        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
# cam_capture_ctrl

Frame-capture sequencer for the camera path, clocked by the camera pixel clock. It arms the pixel writer on a request, starts capture at the next frame boundary (vsync falling edge) and stops at the end of that frame (vsync rising edge). While capturing it checks the frame geometry (lines per frame, writes per line) and reports done or error to the processor-side register block. It supports single-shot and continuous capture, abort, and a watchdog timeout.

## Interface
Parameters:
- H_PIX, 160, pixel writes expected per href line.
- V_LINES, 120, href lines expected per frame.
- TIMEOUT, 500000, pclk cycles allowed in ARM plus CAPT before a timeout error.

Ports (one clock; reset is asynchronous and active-low):
- pclk  in  1  camera pixel clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle capture request; ignored while busy=1.
- cont  in  1  continuous mode; sampled in FIN.
- abort  in  1  cancels any capture in progress.
- vsync  in  1  camera vsync (high = vertical blank).
- href  in  1  camera href (high = line valid).
- px_wr  in  1  pixel-writer strobe, one pulse per stored pixel.
- cap_en  out  1  enables the pixel writer; high only in CAPT.
- addr_clr  out  1  one-cycle pulse that resets the writer address to 0.
- busy  out  1  high in ARM, CAPT and FIN.
- done  out  1  one-cycle pulse on a good frame.
- err  out  1  one-cycle pulse on a failed or aborted frame.
- err_code  out  2  0 none, 1 timeout, 2 geometry, 3 abort. Holds its value until the next accepted start.
- frame_cnt  out  8  count of good frames; wraps 255→0.
- line_cnt  out  $clog2(V_LINES+1)+1  lines seen in the current or last frame; saturates at all-ones.

## Operation
- Edge detect: vs_q and hr_q are the registered previous values of vsync and href.
  - vs_fall = vs_q & ~vsync; vs_rise = ~vs_q & vsync.
  - hr_rise = ~hr_q & href; hr_fall = hr_q & ~href.
- **IDLE**:
  - Outputs: cap_en=0, busy=0.
  - start & ~abort → ARM. In the same transition: clear the timer and err_code, set busy=1.
- **ARM**:
  - vs_fall → CAPT. In the same transition: cap_en=1, addr_clr pulses for one cycle, line_cnt, px_cnt and the geometry-bad flag are cleared.
- **CAPT**:
  - hr_rise: line_cnt+1 (saturating); px_cnt cleared.
  - px_wr while href=1: px_cnt+1, saturating at H_PIX+1.
  - hr_fall: if px_cnt ≠ H_PIX, set the geometry-bad flag.
  - vs_rise → FIN with cap_en=0. The frame is good iff the geometry-bad flag is clear and line_cnt == V_LINES.
- **FIN** (exactly one cycle):
  - Good frame: done=1, frame_cnt+1, err_code=0.
  - Bad frame: err=1, err_code=2.
  - Next state: cont=1 → ARM (timer cleared, busy stays 1); cont=0 → IDLE.
- **Timer**:
  - Counts every cycle in ARM and CAPT.
  - Reaching TIMEOUT-1 → FIN with a forced error: err_code=1, cap_en=0.
- **Abort**:
  - In ARM, CAPT or FIN: next state IDLE, cap_en=0, err=1, err_code=3. No done pulse, frame_cnt unchanged.
  - In IDLE: no effect.
- **Priority within one cycle**: abort > timeout > vs_rise/vs_fall > href/px_wr counting.
- A start pulse arriving while busy=1 is dropped and not queued.

## Timing
- **Reset** (rst=0, asynchronous):
  - State IDLE.
  - cap_en, addr_clr, busy, done, err = 0.
  - err_code=0, frame_cnt=0, line_cnt=0, timer=0.
  - vs_q=1 and hr_q=0, so that no spurious edge is seen on release.
- All outputs are registered. Each one changes on the pclk edge that samples its cause.
- start → busy: 1 cycle.
- vsync falling at the input → cap_en=1 and addr_clr=1: on the same edge that samples vsync=0 with vs_q=1.
- vsync rising → cap_en=0: on the same edge. done or err follows one cycle later, from FIN.
- Continuous mode: FIN→ARM adds no idle gap. A vs_fall sampled in the FIN cycle is missed, so that next frame is skipped; this is the required behaviour.
- Reset asserted mid-frame: cap_en drops asynchronously and no done/err pulse is issued.
- Counter widths:
  - px_cnt: $clog2(H_PIX+2) bits.
  - timer: $clog2(TIMEOUT) bits.
  - frame_cnt: 8 bits, modulo 256.

## Test plan
- Single good frame: H_PIX=4, V_LINES=3; start, then vsync fall, 3 lines of 4 px_wr, vsync rise → one addr_clr, cap_en high only between the edges, done=1 one cycle after vsync rise, frame_cnt=1, err_code=0, busy=0 afterwards.
- Geometry error: same as above with line 2 carrying 3 writes → err=1, err_code=2, frame_cnt=0. Separately, 4 lines of 4 writes → err_code=2, line_cnt=4.
- Timeout: TIMEOUT=50; start with vsync held high → err pulse at cycle 50 after ARM entry, err_code=1, back in IDLE, cap_en never high.
- Abort mid-capture: abort after line 1 → cap_en=0 and err=1 on the next edge, err_code=3, state IDLE. A start issued during capture is ignored (busy stays 1, no second addr_clr).
- Continuous mode: cont=1, three good frames in sequence → three done pulses, frame_cnt=3, busy held high throughout. Then start from frame_cnt=255 → wraps to 0.
- Reset mid-CAPT: rst=0 asynchronously → all outputs 0 immediately. After release, a vsync already low produces no capture until a fresh start.
